// File: rtl/adc_avg_filter.sv
// Block-average filter for one XADC channel: averages N = 2^LOG2_N accepted
// conversions, publishes the truncated mean with a one-cycle strobe, and tracks the peak mean.
module adc_avg_filter #(
  parameter int          LOG2_N = 3,
  parameter logic [4:0]  CHAN   = 5'h10
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        DRDY,
  input  logic [15:0] DO,
  input  logic [4:0]  CHANNEL,
  input  logic        PEAK_CLR,
  output logic [11:0] V_AVG,
  output logic        AVG_VALID,
  output logic [11:0] V_PEAK,
  output logic        BUSY
);

  localparam int AW = 12 + LOG2_N;

  typedef enum logic {IDLE, ACC} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [11:0]       avg_q, avg_d;
  logic              valid_q, valid_d;
  logic [11:0]       peak_q, peak_d;

  logic          accept;
  logic [11:0]   sample;
  logic [AW-1:0] sum;
  logic [11:0]   avg_new;
  logic          last;
  logic          unused_do;

  assign accept    = DRDY && (CHANNEL == CHAN) && EN;
  assign sample    = DO[15:4];
  assign unused_do = ^DO[3:0];
  // The accumulator only ever holds N-1 samples, so adding the Nth cannot wrap.
  assign sum       = acc_q + {{LOG2_N{1'b0}}, sample};
  assign avg_new   = sum[AW-1:LOG2_N];
  assign last      = (cnt_q == {LOG2_N{1'b1}});

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    valid_d = 1'b0;
    peak_d  = peak_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACC;
          acc_d   = {{LOG2_N{1'b0}}, sample};
          cnt_d   = LOG2_N'(1);
        end
      end
      ACC: begin
        if (!EN) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (accept) begin
          if (last) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            avg_d   = avg_new;
            valid_d = 1'b1;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + LOG2_N'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // A clear issued while the strobe is out keeps the freshly published average.
    if (valid_d) begin
      peak_d = (PEAK_CLR || (avg_new > peak_q)) ? avg_new : peak_q;
    end else if (PEAK_CLR) begin
      peak_d = valid_q ? avg_q : 12'h000;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      peak_q  <= peak_d;
    end
  end

  assign V_AVG     = avg_q;
  assign AVG_VALID = valid_q;
  assign V_PEAK    = peak_q;
  assign BUSY      = (state_q == ACC);

endmodule

// File: tb/tb_adc_avg_filter.sv
// Self-checking bench for adc_avg_filter: table vectors, directed corner sequences
// and randomized traffic, all checked against a sample-list reference model.
module tb_adc_avg_filter;

  localparam int         LOG2_N = 3;
  localparam int         N      = 8;
  localparam logic [4:0] CHAN   = 5'h10;
  localparam logic [4:0] OTHER  = 5'h11;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic        DRDY;
  logic [15:0] DO;
  logic [4:0]  CHANNEL;
  logic        PEAK_CLR;
  logic [11:0] V_AVG;
  logic        AVG_VALID;
  logic [11:0] V_PEAK;
  logic        BUSY;

  adc_avg_filter #(.LOG2_N(LOG2_N), .CHAN(CHAN)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .DRDY(DRDY), .DO(DO),
    .CHANNEL(CHANNEL), .PEAK_CLR(PEAK_CLR), .V_AVG(V_AVG),
    .AVG_VALID(AVG_VALID), .V_PEAK(V_PEAK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: the samples of the current block, plus the published values.
  int blk[$];
  int mAvg;
  int mPeak;
  bit mValid;

  typedef struct {
    bit          en;
    bit          drdy;
    logic [4:0]  ch;
    logic [11:0] s;
    bit          pclr;
    logic [11:0] eAvg;
    bit          eValid;
    logic [11:0] ePeak;
    bit          eBusy;
  } vec_t;

  vec_t tbl[$];

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("v_avg", V_AVG, 16'(mAvg));
    checkVal("avg_valid", AVG_VALID, 16'(mValid));
    checkVal("v_peak", V_PEAK, 16'(mPeak));
    checkVal("busy", BUSY, 16'(blk.size() > 0));
  endtask

  task automatic modelReset();
    blk.delete();
    mAvg   = 0;
    mPeak  = 0;
    mValid = 0;
  endtask

  task automatic modelStep(input bit en, input bit drdy, input logic [4:0] ch,
                           input logic [11:0] s, input bit pclr);
    bit hit;
    bit newValid;
    int tot;
    int navg;
    int base;
    hit      = drdy && en && (ch == CHAN);
    newValid = 0;
    navg     = 0;
    if (!en) blk.delete();
    if (hit) begin
      blk.push_back(int'(s));
      if (blk.size() == N) begin
        tot = 0;
        foreach (blk[k]) tot += blk[k];
        navg     = tot / N;
        newValid = 1;
        blk.delete();
      end
    end
    if (newValid) begin
      base  = pclr ? 0 : mPeak;
      mPeak = (navg > base) ? navg : base;
      mAvg  = navg;
    end else if (pclr) begin
      mPeak = mValid ? mAvg : 0;
    end
    mValid = newValid;
  endtask

  // Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the next one.
  task automatic applyStimulus(input bit en, input bit drdy, input logic [4:0] ch,
                               input logic [11:0] s, input bit pclr);
    EN       = en;
    DRDY     = drdy;
    CHANNEL  = ch;
    DO       = {s, 4'($urandom)};
    PEAK_CLR = pclr;
    modelStep(en, drdy, ch, s, pclr);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic feed(input logic [11:0] s, input int gap);
    applyStimulus(1'b1, 1'b1, CHAN, s, 1'b0);
    for (int g = 0; g < gap; g++) applyStimulus(1'b1, 1'b0, CHAN, 12'h000, 1'b0);
  endtask

  task automatic doReset();
    #2;
    RST_N = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    EN    = 1'b1;
    DRDY  = 1'b0;
    checkOutput();
  endtask

  initial begin
    vec_t v;
    RST_N = 1'b0; EN = 1'b0; DRDY = 1'b0; DO = '0; CHANNEL = '0; PEAK_CLR = 1'b0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput();
    RST_N = 1'b1;

    // Eight mid-scale samples: strobe exactly one cycle after the 8th DRDY.
    for (int i = 0; i < N; i++) begin
      v.en = 1; v.drdy = 1; v.ch = CHAN; v.s = 12'h800; v.pclr = 0;
      v.eAvg   = (i == N-1) ? 12'h800 : 12'h000;
      v.eValid = (i == N-1);
      v.ePeak  = (i == N-1) ? 12'h800 : 12'h000;
      v.eBusy  = (i < N-1);
      tbl.push_back(v);
    end
    v.en = 1; v.drdy = 0; v.ch = CHAN; v.s = 12'h000; v.pclr = 0;
    v.eAvg = 12'h800; v.eValid = 0; v.ePeak = 12'h800; v.eBusy = 0;
    tbl.push_back(v);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].en, tbl[i].drdy, tbl[i].ch, tbl[i].s, tbl[i].pclr);
      checkVal("tbl_avg", V_AVG, 16'(tbl[i].eAvg));
      checkVal("tbl_valid", AVG_VALID, 16'(tbl[i].eValid));
      checkVal("tbl_peak", V_PEAK, 16'(tbl[i].ePeak));
      checkVal("tbl_busy", BUSY, 16'(tbl[i].eBusy));
    end

    // Ramp block then a tiny block whose mean truncates; peak stays at the ramp mean.
    doReset();
    for (int i = 0; i < N; i++) feed(12'(i * 'h100), 1);
    checkVal("ramp_avg", V_AVG, 16'h380);
    for (int i = 1; i <= N; i++) feed(12'(i), 1);
    checkVal("trunc_avg", V_AVG, 16'h004);
    checkVal("trunc_peak", V_PEAK, 16'h380);

    // Full-scale samples must not wrap.
    doReset();
    for (int i = 0; i < N; i++) feed(12'hFFF, 1);
    checkVal("fullscale_avg", V_AVG, 16'hFFF);

    // Foreign-channel conversions interleaved with our own are ignored.
    doReset();
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b1, 1'b1, OTHER, 12'hABC, 1'b0);
      applyStimulus(1'b1, 1'b1, CHAN, 12'h300, 1'b0);
      checkVal("chan_valid", AVG_VALID, 16'(i == N-1));
    end
    checkVal("chan_avg", V_AVG, 16'h300);

    // Enable drop discards a partial block; clear coincident with strobe keeps new mean.
    doReset();
    for (int i = 0; i < N; i++) feed(12'h900, 1);
    for (int i = 0; i < 5; i++) feed(12'h700, 1);
    applyStimulus(1'b0, 1'b0, CHAN, 12'h000, 1'b0);
    checkVal("endrop_busy", BUSY, 16'h0);
    applyStimulus(1'b0, 1'b1, CHAN, 12'hFFF, 1'b0);
    checkVal("endrop_avg_hold", V_AVG, 16'h900);
    for (int i = 0; i < N-1; i++) feed(12'h200, 1);
    applyStimulus(1'b1, 1'b1, CHAN, 12'h200, 1'b0);
    applyStimulus(1'b1, 1'b0, CHAN, 12'h000, 1'b1);
    checkVal("clr_coincident_peak", V_PEAK, 16'h200);
    checkVal("endrop_avg", V_AVG, 16'h200);
    applyStimulus(1'b1, 1'b0, CHAN, 12'h000, 1'b1);
    checkVal("clr_plain_peak", V_PEAK, 16'h000);

    // Reset mid-block clears everything asynchronously; next block starts clean.
    doReset();
    for (int i = 0; i < N; i++) feed(12'h500, 1);
    for (int i = 0; i < 4; i++) feed(12'hA00, 1);
    #2;
    RST_N = 1'b0;
    modelReset();
    #1;
    checkVal("async_avg", V_AVG, 16'h0);
    checkVal("async_peak", V_PEAK, 16'h0);
    checkVal("async_busy", BUSY, 16'h0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < N; i++) feed(12'h100, 1);
    checkVal("post_reset_avg", V_AVG, 16'h100);

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0,
                    ($urandom_range(0, 3) == 0) ? OTHER : CHAN,
                    12'($urandom), $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
